// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: moves bytes between C64 memory and REU RAM one PHI2
// cycle at a time, in stash, fetch, swap and verify modes. Commands to the
// RAM controller are registered and only change on a CYC pulse. Each one
// therefore stays valid for the whole PHI2 cycle that follows.
module reu_dma_seq #(
  parameter logic [23:0] REUMASK = 24'hFFFFFF
) (
  input  logic        C8M,
  input  logic        RESET,
  input  logic        CYC,
  input  logic        START,
  input  logic [1:0]  MODE,
  input  logic [15:0] C64A0,
  input  logic [23:0] REUA0,
  input  logic [15:0] LEN0,
  input  logic        FIXC64,
  input  logic        FIXREU,
  input  logic        AUTOLOAD,
  output logic        BUSREQ,
  input  logic        BUSGNT,
  output logic        RDCMD,
  output logic        WRCMD,
  output logic [23:0] A,
  output logic [15:0] CA,
  output logic        CRW,
  output logic        WSEL,
  output logic        CDSEL,
  input  logic [7:0]  DIN,
  input  logic [7:0]  RDD,
  output logic [7:0]  HOLDC,
  output logic [7:0]  HOLDR,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAULT,
  output logic [15:0] REM
);

  localparam logic [1:0] MODE_STASH  = 2'd0;
  localparam logic [1:0] MODE_FETCH  = 2'd1;
  localparam logic [1:0] MODE_SWAP   = 2'd2;
  localparam logic [1:0] MODE_VERIFY = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_XFER, S_SWAP2, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] a_q, a_d;
  logic [15:0] ca_q, ca_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  holdc_q, holdc_d;
  logic [7:0]  holdr_q, holdr_d;
  logic        fault_q, fault_d;
  logic        rdcmd_q, rdcmd_d;
  logic        wrcmd_q, wrcmd_d;
  logic        crw_q, crw_d;
  logic        wsel_q, wsel_d;
  logic        cdsel_q, cdsel_d;
  logic [1:0]  mode_q, mode_d;
  logic        fixc_q, fixc_d;
  logic        fixr_q, fixr_d;
  logic        auto_q, auto_d;

  // Per-CYC bookkeeping: cmd_upd re-evaluates the command set, issue says
  // whether the next PHI2 cycle carries a command at all.
  logic        cmd_upd;
  logic        issue;

  // State and datapath registers.
  always_ff @(posedge C8M or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      ca_q    <= '0;
      rem_q   <= '0;
      holdc_q <= '0;
      holdr_q <= '0;
      fault_q <= 1'b0;
      rdcmd_q <= 1'b0;
      wrcmd_q <= 1'b0;
      crw_q   <= 1'b1;
      wsel_q  <= 1'b0;
      cdsel_q <= 1'b0;
      mode_q  <= MODE_STASH;
      fixc_q  <= 1'b0;
      fixr_q  <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ca_q    <= ca_d;
      rem_q   <= rem_d;
      holdc_q <= holdc_d;
      holdr_q <= holdr_d;
      fault_q <= fault_d;
      rdcmd_q <= rdcmd_d;
      wrcmd_q <= wrcmd_d;
      crw_q   <= crw_d;
      wsel_q  <= wsel_d;
      cdsel_q <= cdsel_d;
      mode_q  <= mode_d;
      fixc_q  <= fixc_d;
      fixr_q  <= fixr_d;
      auto_q  <= auto_d;
    end
  end

  // Next state: complete the byte of the PHI2 cycle just ended, then set up the next one.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ca_d    = ca_q;
    rem_d   = rem_q;
    holdc_d = holdc_q;
    holdr_d = holdr_q;
    fault_d = fault_q;
    rdcmd_d = rdcmd_q;
    wrcmd_d = wrcmd_q;
    crw_d   = crw_q;
    wsel_d  = wsel_q;
    cdsel_d = cdsel_q;
    mode_d  = mode_q;
    fixc_d  = fixc_q;
    fixr_d  = fixr_q;
    auto_d  = auto_q;
    cmd_upd = 1'b0;
    issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = REUA0;
          ca_d    = C64A0;
          rem_d   = LEN0;
          fault_d = 1'b0;
          mode_d  = MODE;
          fixc_d  = FIXC64;
          fixr_d  = FIXREU;
          auto_d  = AUTOLOAD;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (CYC && BUSGNT) begin
          state_d = S_XFER;
          cmd_upd = 1'b1;
          issue   = 1'b1;
        end
      end

      S_XFER, S_SWAP2: begin
        if (CYC) begin
          cmd_upd = 1'b1;
          issue   = BUSGNT;
          // Only a cycle that actually carried a command has a byte to finish.
          if (rdcmd_q || wrcmd_q) begin
            if (state_q == S_XFER && mode_q == MODE_VERIFY && DIN != RDD) begin
              fault_d = 1'b1;
              state_d = S_FIN;
              issue   = 1'b0;
            end else if (state_q == S_XFER && mode_q == MODE_SWAP) begin
              holdc_d = DIN;
              holdr_d = RDD;
              state_d = S_SWAP2;
            end else begin
              if (!fixc_q) ca_d = ca_q + 16'd1;
              if (!fixr_q) a_d = (a_q + 24'd1) & REUMASK;
              rem_d = rem_q - 16'd1;
              if (rem_q == 16'd1) begin
                state_d = S_FIN;
                issue   = 1'b0;
              end else begin
                state_d = S_XFER;
              end
            end
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (auto_q) begin
          a_d   = REUA0;
          ca_d  = C64A0;
          rem_d = LEN0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Command set for the coming PHI2 cycle; an ungranted cycle stays quiet.
    if (cmd_upd) begin
      rdcmd_d = 1'b0;
      wrcmd_d = 1'b0;
      crw_d   = 1'b1;
      wsel_d  = 1'b0;
      cdsel_d = 1'b0;
      if (issue) begin
        if (state_d == S_SWAP2) begin
          wrcmd_d = 1'b1;
          wsel_d  = 1'b1;
          crw_d   = 1'b0;
          cdsel_d = 1'b1;
        end else if (state_d == S_XFER) begin
          case (mode_q)
            MODE_STASH:  wrcmd_d = 1'b1;
            MODE_FETCH: begin
              rdcmd_d = 1'b1;
              crw_d   = 1'b0;
            end
            default:     rdcmd_d = 1'b1;
          endcase
        end
      end
    end
  end

  // Outputs decoded from the state plus the registered command set.
  always_comb begin
    BUSREQ = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_SWAP2);
    BUSY   = BUSREQ;
    DONE   = (state_q == S_FIN);
    RDCMD  = rdcmd_q;
    WRCMD  = wrcmd_q;
    CRW    = crw_q;
    WSEL   = wsel_q;
    CDSEL  = cdsel_q;
    A      = a_q;
    CA     = ca_q;
    REM    = rem_q;
    FAULT  = fault_q;
    HOLDC  = holdc_q;
    HOLDR  = holdr_q;
  end

endmodule
